// File: rtl/rsa_pkg.sv
// rtl/rsa_pkg.sv - shared types and sizing helpers for the modular-exponentiation core
package rsa_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        INIT,
        EXP,
        FINAL,
        DONE
    } rsa_state_e;

    // Two guard bits keep unreduced Montgomery results below 2M.
    function automatic int mont_width(input int width);
        return width + 2;
    endfunction

    // Enabled cycles from accept to done for a given number of exponent rounds.
    function automatic int rsa_latency(input int rounds, input int width);
        return (rounds + 2) * (mont_width(width) + 1) + 2;
    endfunction

endpackage

// File: rtl/mmm_serial.sv
// rtl/mmm_serial.sv - bit-serial Montgomery product R = A*B*2^-N mod M in N+1 cycles
module mmm_serial #(
    parameter int N = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ena,
    input  logic         load,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic [N-1:0] M,
    output logic [N-1:0] R,
    output logic         ready
);
    localparam int CW = $clog2(N + 1);

    logic [N-1:0]  a_q, b_q, m_q, t_q;
    logic [CW-1:0] cnt_q;
    logic [N:0]    sum, sum_m;
    logic [N-1:0]  t_next;

    always_comb begin
        sum    = {1'b0, t_q} + (a_q[0] ? {1'b0, b_q} : '0);
        sum_m  = sum[0] ? sum + {1'b0, m_q} : sum;
        t_next = N'(sum_m >> 1);
    end

    // ready marks the final iteration; R already shows the finished product then.
    assign ready = (cnt_q == CW'(1));
    assign R     = ready ? t_next : t_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            t_q   <= '0;
        end else if (ena) begin
            if (load) begin
                cnt_q <= CW'(N);
                t_q   <= '0;
            end else if (cnt_q != '0) begin
                cnt_q <= cnt_q - CW'(1);
                t_q   <= t_next;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (ena) begin
            if (load) begin
                a_q <= A;
                b_q <= B;
                m_q <= M;
            end else if (cnt_q != '0) begin
                a_q <= a_q >> 1;
            end
        end
    end

endmodule

// File: rtl/rsa_modexp_core.sv
// rtl/rsa_modexp_core.sv - C = P^E mod M with parallel multiply/square Montgomery paths
// Optional RSA_EARLY_EXIT_EN stops exponent rounds after the highest set bit of E.
module rsa_modexp_core
    import rsa_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int EXP_WIDTH = WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ena,
    input  logic                 start,
    input  logic [WIDTH-1:0]     P,
    input  logic [EXP_WIDTH-1:0] E,
    input  logic [WIDTH-1:0]     M,
    input  logic [WIDTH-1:0]     Const,
    output logic [WIDTH-1:0]     C,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);
    localparam int N = mont_width(WIDTH);
    localparam logic [N-1:0] ONE = N'(1);

    rsa_state_e state_q, state_d;
    logic first_q, first_d;
    logic [WIDTH-1:0]     p_q, m_q, k_q, c_q;
    logic [EXP_WIDTH-1:0] e_q;
    logic err_q;
    logic accept, last_round;

    logic [N-1:0] mul_a, mul_b, mul_r, sq_a, sq_b, sq_r, m_ext;
    logic mul_load, sq_load, mul_ready, sq_ready;

    assign busy   = (state_q != IDLE) && (state_q != DONE);
    assign done   = (state_q == DONE);
    assign accept = ena && start && !busy;
    assign C      = c_q;
    assign err    = err_q;
    assign m_ext  = {2'b00, m_q};

`ifdef RSA_EARLY_EXIT_EN
    assign last_round = (e_q[EXP_WIDTH-1:1] == '0);
`else
    localparam int IW = $clog2(EXP_WIDTH + 1);
    logic [IW-1:0] i_q;

    assign last_round = (i_q == IW'(EXP_WIDTH - 1));

    always_ff @(posedge clk) begin
        if (ena) begin
            if (accept)
                i_q <= '0;
            else if (state_q == EXP && sq_ready)
                i_q <= i_q + IW'(1);
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (accept) state_d = CHECK;
            CHECK: state_d = m_q[0] ? INIT : DONE;
            INIT: begin
                if (sq_ready) begin
`ifdef RSA_EARLY_EXIT_EN
                    state_d = (e_q == '0) ? FINAL : EXP;
`else
                    state_d = EXP;
`endif
                end
            end
            EXP:   if (sq_ready && last_round) state_d = FINAL;
            FINAL: if (mul_ready) state_d = DONE;
            DONE:  state_d = accept ? CHECK : IDLE;
            default: state_d = IDLE;
        endcase
        // Every product phase, including each new exponent round, opens with a load cycle.
        first_d = (state_d != state_q) || (state_q == EXP && sq_ready);
    end

    assign mul_a    = (state_q == INIT) ? {2'b00, k_q} : mul_r;
    assign mul_b    = (state_q == EXP) ? sq_r : ONE;
    assign sq_a     = (state_q == INIT) ? {2'b00, k_q} : sq_r;
    assign sq_b     = (state_q == INIT) ? {2'b00, p_q} : sq_r;
    assign mul_load = first_q && ((state_q == INIT) || (state_q == FINAL) ||
                                  (state_q == EXP && e_q[0]));
    assign sq_load  = first_q && ((state_q == INIT) || (state_q == EXP));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            first_q <= 1'b0;
            c_q     <= '0;
            err_q   <= 1'b0;
        end else if (ena) begin
            state_q <= state_d;
            first_q <= first_d;
            if (accept)
                err_q <= 1'b0;
            if (state_q == CHECK && !m_q[0]) begin
                err_q <= 1'b1;
                c_q   <= '0;
            end
            // Products stay below 2M, so one conditional subtract fully reduces.
            if (state_q == FINAL && mul_ready)
                c_q <= WIDTH'((mul_r >= m_ext) ? mul_r - m_ext : mul_r);
        end
    end

    always_ff @(posedge clk) begin
        if (ena) begin
            if (accept) begin
                p_q <= P;
                e_q <= E;
                m_q <= M;
                k_q <= Const;
            end else if (state_q == EXP && sq_ready) begin
                e_q <= e_q >> 1;
            end
        end
    end

    mmm_serial #(.N(N)) u_mul (
        .clk   (clk),
        .rst   (rst),
        .ena   (ena),
        .load  (mul_load),
        .A     (mul_a),
        .B     (mul_b),
        .M     (m_ext),
        .R     (mul_r),
        .ready (mul_ready)
    );

    mmm_serial #(.N(N)) u_sq (
        .clk   (clk),
        .rst   (rst),
        .ena   (ena),
        .load  (sq_load),
        .A     (sq_a),
        .B     (sq_b),
        .M     (m_ext),
        .R     (sq_r),
        .ready (sq_ready)
    );

endmodule

// File: tb/tb_rsa_modexp_core.sv
// tb/tb_rsa_modexp_core.sv - directed and randomized checks of rsa_modexp_core against a behavioural model
module tb_rsa_modexp_core;
    import rsa_pkg::*;

    localparam int W     = 8;
    localparam int EXP_W = 8;

`ifdef RSA_EARLY_EXIT_EN
    localparam int LAT_P5   = 46;
    localparam int LAT_E0   = 24;
    localparam int LAT_P0   = 57;
`else
    localparam int LAT_P5   = 112;
    localparam int LAT_E0   = 112;
    localparam int LAT_P0   = 112;
`endif
    localparam int LAT_FULL = 112;

    logic clk, rst, ena, start;
    logic [W-1:0] P, M, Const, C;
    logic [EXP_W-1:0] E;
    logic busy, done, err;

    int  vectors = 0;
    int  miscompares = 0;
    bit  chk_en = 0;
    bit  rand_ena = 0;

    rsa_modexp_core #(.WIDTH(W), .EXP_WIDTH(EXP_W)) dut (
        .clk   (clk),
        .rst   (rst),
        .ena   (ena),
        .start (start),
        .P     (P),
        .E     (E),
        .M     (M),
        .Const (Const),
        .C     (C),
        .busy  (busy),
        .done  (done),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int modexp(input int p, input int e, input int m);
        longint r = 1;
        for (int i = 0; i < e; i++) r = (r * p) % m;
        return int'(r % m);
    endfunction

    function automatic int const_of(input int m);
        return int'((longint'(1) << (2 * (W + 2))) % m);
    endfunction

    function automatic int exp_lat(input logic [EXP_W-1:0] e, input logic [W-1:0] m);
        int rounds;
        if (!m[0]) return 2;
        rounds = EXP_W;
`ifdef RSA_EARLY_EXIT_EN
        rounds = 0;
        for (int b = 0; b < EXP_W; b++) if (e[b]) rounds = b + 1;
`endif
        return rsa_latency(rounds, W);
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: counts enabled cycles since the accepted start.
    bit m_active = 0, m_err = 0, m_errv = 0, m_busy;
    int m_n = 0, m_L = 0, m_res = 0;
    logic [W-1:0] m_c = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_active = 0;
            m_c      = '0;
            m_err    = 0;
        end else if (ena) begin
            m_busy = m_active && (m_n < m_L - 1);
            if (m_active) begin
                m_n++;
                if (m_n == m_L - 1) begin
                    m_c = W'(m_res);
                    if (m_errv) m_err = 1;
                end
                if (m_n >= m_L) m_active = 0;
            end
            if (start && !m_busy) begin
                m_active = 1;
                m_n      = 0;
                m_err    = 0;
                m_errv   = !M[0];
                m_res    = M[0] ? modexp(int'(P), int'(E), int'(M)) : 0;
                m_L      = exp_lat(E, M);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", busy, m_active && (m_n < m_L - 1));
            chk("done", done, m_active && (m_n == m_L - 1));
            chk("C", C, m_c);
            chk("err", err, m_err);
        end
    end

    task automatic step();
        @(negedge clk);
        if (rand_ena) ena = ($urandom_range(0, 7) != 0);
    endtask

    task automatic rand_operands();
        int m;
        m = $urandom_range(3, 255);
        if ($urandom_range(0, 9) != 0) m = m | 1;
        M     = W'(m);
        P     = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom_range(0, m - 1));
        E     = ($urandom_range(0, 7) == 0) ? '0 : EXP_W'($urandom);
        Const = W'(const_of(m));
    endtask

    task automatic run_dir(input int p, input int e, input int m, input int gap_at,
                           input int exp_c, input int exp_err, input int exp_lat_v,
                           input string name);
        int cyc;
        bit seen;
        P = W'(p); E = EXP_W'(e); M = W'(m); Const = W'(const_of(m));
        ena = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({name, "_err_on_accept"}, err, 0);
        cyc = 0;
        seen = 0;
        while (!seen && cyc < 2000) begin
            if (done) begin
                seen = 1;
            end else begin
                ena = (gap_at >= 0 && cyc >= gap_at && cyc < gap_at + 20) ? 1'b0 : 1'b1;
                @(negedge clk);
                cyc++;
            end
        end
        ena = 1'b1;
        chk({name, "_done_seen"}, seen, 1);
        chk({name, "_C"}, C, exp_c);
        chk({name, "_err"}, err, exp_err);
        chk({name, "_latency"}, cyc + 1, exp_lat_v);
    endtask

    initial begin
        bit acc, seen;
        rst = 1'b1; ena = 1'b1; start = 1'b0;
        P = '0; E = '0; M = '0; Const = '0;
        repeat (3) @(negedge clk);
        chk_en = 1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_C", C, 0);
        chk("rst_err", err, 0);
        rst = 1'b0;

        chk("model_5_3_13", modexp(5, 3, 13), 8);
        chk("model_200_255_251", modexp(200, 255, 251), 102);
        chk("model_e0", modexp(7, 0, 13), 1);
        chk("model_const_251", const_of(251), 149);

        run_dir(5, 3, 13, -1, 8, 0, LAT_P5, "p5");
        run_dir(200, 255, 251, -1, 102, 0, LAT_FULL, "p200");
        run_dir(7, 0, 13, -1, 1, 0, LAT_E0, "e0");
        run_dir(0, 5, 13, -1, 0, 0, LAT_P0, "p0");
        run_dir(9, 7, 12, -1, 0, 1, 2, "even");
        run_dir(5, 3, 13, 30, 8, 0, LAT_P5 + 20, "ena_gap");

        P = 8'd5; E = 8'd3; M = 8'd13; Const = 8'd9;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (40) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_C", C, 0);
        rst = 1'b0;
        run_dir(5, 3, 13, -1, 8, 0, LAT_P5, "after_rst");

        rand_ena = 1;
        for (int op = 0; op < 40; op++) begin
            rand_operands();
            start = 1'b1;
            acc = 0;
            for (int t = 0; t < 50 && !acc; t++) begin
                acc = ena;
                step();
            end
            start = 1'b0;
            chk("rand_accept", acc, 1);
            seen = 0;
            for (int t = 0; t < 1000 && !seen; t++) begin
                if (done) begin
                    seen = 1;
                    start = 1'b0;
                end else begin
                    if (busy && $urandom_range(0, 15) == 0) begin
                        rand_operands();
                        start = 1'b1;
                    end else begin
                        start = 1'b0;
                    end
                    step();
                end
            end
            chk("rand_done_seen", seen, 1);
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 3)) step();
            end
        end
        rand_ena = 0;
        ena = 1'b1;
        start = 1'b0;
        repeat (5) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
